// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned multiply/divide unit beside the ALU.
// Each multiply or divide runs one bit per clock over DATA_W cycles. The unit
// then raises a single write-back strobe toward the register file.
module mul_div_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk_150_mhz,
  input  logic              reg_rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W:0]     rem;
  logic [DATA_W-1:0]   divisor;

  logic                is_div;
  logic                div_zero;
  logic                last_step;
  logic [2*DATA_W-1:0] acc_step;
  logic [DATA_W:0]     rem_shift;
  logic                rem_ge;
  logic [DATA_W:0]     rem_step;
  logic [DATA_W-1:0]   quo_step;
  logic [DATA_W-1:0]   result;

  // shreg holds the multiplier (consumed LSB first) or the dividend that turns into the quotient
  assign is_div    = op_q[1];
  assign div_zero  = (divisor == '0);
  assign last_step = (cnt == LAST_ITER);
  assign busy      = (state != IDLE);
  assign wb_en     = (state == DONE);

  // One shift-add or restoring-division step, plus the final result selection
  always_comb begin
    acc_step  = shreg[0] ? (acc + mcand) : acc;
    rem_shift = {rem[DATA_W-1:0], shreg[DATA_W-1]};
    rem_ge    = (rem_shift >= {1'b0, divisor});
    rem_step  = rem_ge ? (rem_shift - {1'b0, divisor}) : rem_shift;
    quo_step  = {shreg[DATA_W-2:0], rem_ge};
    result    = '0;
    if (is_div && div_zero) begin
      result = (op_q == OP_DIVU) ? '1 : shreg;
    end else begin
      case (op_q)
        OP_MUL:   result = acc_step[DATA_W-1:0];
        OP_MULHU: result = acc_step[2*DATA_W-1:DATA_W];
        OP_DIVU:  result = quo_step;
        default:  result = rem_step[DATA_W-1:0];
      endcase
    end
  end

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk_150_mhz or negedge reg_rst_n) begin
    if (!reg_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next state: a zero divisor is caught on the first RUN cycle and skips the iterations
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if ((is_div && div_zero) || last_step) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-cycle iteration, and result/destination capture on entry to DONE
  always_ff @(posedge clk_150_mhz or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      op_q    <= '0;
      rd_q    <= '0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      shreg   <= '0;
      rem     <= '0;
      divisor <= '0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            rd_q    <= rd_addr;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= {{DATA_W{1'b0}}, rs1_data};
            shreg   <= op[1] ? rs1_data : rs2_data;
            rem     <= '0;
            divisor <= rs2_data;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            shreg <= quo_step;
            rem   <= rem_step;
          end else begin
            acc   <= acc_step;
            mcand <= mcand << 1;
            shreg <= shreg >> 1;
          end
          if (state_nxt == DONE) begin
            wb_addr <= rd_q;
            wb_data <= result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
